// File: rtl/itof_rm_pipe_if.sv
// itof_rm_pipe_if: operand/result valid-ready channels of the integer-to-binary32 converter
interface itof_rm_pipe_if #(
   parameter int IN_W  = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             in_unsigned;
   logic [2:0]       in_rm;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic             out_nx;
   logic [TAG_W-1:0] out_tag;
   modport master (
      output in_valid, in_data, in_unsigned, in_rm, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_nx, out_tag
   );
   modport slave (
      input  in_valid, in_data, in_unsigned, in_rm, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_nx, out_tag
   );
endinterface

// File: rtl/itof_rm_pipe.sv
// itof_rm_pipe: 3-stage integer to IEEE-754 binary32 converter with valid/ready flow control.
// ITOF_RM_PIPE_ROUND_MODES_EN enables per-operand rounding modes; otherwise all results use RNE.
module itof_rm_pipe #(
   parameter int IN_W  = 32,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic rst_n,
   itof_rm_pipe_if.slave io
);
   localparam int LW = $clog2(IN_W + 1);
   localparam int W  = IN_W + 25;
   logic             v1, v2, v3, en1, en2, en3;
   logic             sgn, s1, s2;
   logic [IN_W-1:0]  mag, m1, m2, nrm;
   logic [TAG_W-1:0] t1, t2, t3;
   logic [LW-1:0]    lz, lz2;
   logic [W-1:0]     ext;
   logic [22:0]      man;
   logic [7:0]       ex;
   logic             g, st, inc, z, nx3;
   logic [31:0]      d3;
`ifdef ITOF_RM_PIPE_ROUND_MODES_EN
   logic [2:0]       r1, r2;
`else
   logic             unused_rm;
   assign unused_rm = ^io.in_rm;
`endif
   assign en3         = !v3 || io.out_ready;
   assign en2         = !v2 || en3;
   assign en1         = !v1 || en2;
   assign io.in_ready = en1;
   assign io.out_valid = v3;
   assign io.out_data  = d3;
   assign io.out_nx    = nx3;
   assign io.out_tag   = t3;
   assign sgn = !io.in_unsigned && io.in_data[IN_W-1];
   assign mag = sgn ? -io.in_data : io.in_data;
   // highest set bit wins; an all-zero magnitude reports IN_W
   always_comb begin
      lz = LW'(IN_W);
      for (int i = 0; i < IN_W; i++)
         if (m1[i]) lz = LW'(IN_W - 1 - i);
   end
   // zero padding below the operand makes G and S vanish for narrow inputs
   always_comb begin
      z   = ~|m2;
      nrm = m2 << lz2;
      ext = {nrm, 25'd0};
      man = ext[W-2 -: 23];
      g   = ext[W-25];
      st  = |ext[W-26:0];
      ex  = 8'(127 + IN_W - 1 - int'(lz2));
`ifdef ITOF_RM_PIPE_ROUND_MODES_EN
      inc = (r2 == 3'd1) ? 1'b0 :
            (r2 == 3'd2) ? (g || st) && s2 :
            (r2 == 3'd3) ? (g || st) && !s2 :
            (r2 == 3'd4) ? g :
                           g && (st || man[0]);
`else
      inc = g && (st || man[0]);
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         d3  <= '0;
         nx3 <= 1'b0;
         t3  <= '0;
      end else begin
         if (en1) v1 <= io.in_valid;
         if (en2) v2 <= v1;
         if (en3) v3 <= v2;
         if (en1 && io.in_valid) begin
            s1 <= sgn;
            m1 <= mag;
            t1 <= io.in_tag;
`ifdef ITOF_RM_PIPE_ROUND_MODES_EN
            r1 <= io.in_rm;
`endif
         end
         if (en2 && v1) begin
            s2  <= s1;
            m2  <= m1;
            lz2 <= lz;
            t2  <= t1;
`ifdef ITOF_RM_PIPE_ROUND_MODES_EN
            r2  <= r1;
`endif
         end
         // carry out of the mantissa rolls into the exponent field
         if (en3 && v2) begin
            d3  <= z ? 32'd0 : {s2, {ex, man} + 31'(inc)};
            nx3 <= !z && (g || st);
            t3  <= t2;
         end
      end
   end
endmodule

// File: tb/tb_itof_rm_pipe.sv
// tb_itof_rm_pipe: scoreboard bench for itof_rm_pipe (IN_W=32, TAG_W=4)
module tb_itof_rm_pipe;
   typedef struct packed {
      logic [31:0] d;
      logic        nx;
      logic [3:0]  t;
   } exp_t;
   typedef struct packed {
      logic [31:0] d;
      logic        u;
      logic [2:0]  rm;
      logic [31:0] e_rm;
      logic [31:0] e_rne;
      logic        nx;
   } vec_t;
`ifdef ITOF_RM_PIPE_ROUND_MODES_EN
   localparam bit RM_EN = 1'b1;
`else
   localparam bit RM_EN = 1'b0;
`endif
   localparam vec_t VECS [14] = '{
      '{32'h00000001, 1'b0, 3'd0, 32'h3F800000, 32'h3F800000, 1'b0},
      '{32'h00000000, 1'b0, 3'd0, 32'h00000000, 32'h00000000, 1'b0},
      '{32'h00000000, 1'b1, 3'd1, 32'h00000000, 32'h00000000, 1'b0},
      '{32'h00000000, 1'b0, 3'd2, 32'h00000000, 32'h00000000, 1'b0},
      '{32'h00000000, 1'b1, 3'd3, 32'h00000000, 32'h00000000, 1'b0},
      '{32'h00000000, 1'b0, 3'd4, 32'h00000000, 32'h00000000, 1'b0},
      '{32'hFFFFFFFF, 1'b0, 3'd0, 32'hBF800000, 32'hBF800000, 1'b0},
      '{32'hFFFFFFFF, 1'b1, 3'd0, 32'h4F800000, 32'h4F800000, 1'b1},
      '{32'hFFFFFFFF, 1'b1, 3'd1, 32'h4F7FFFFF, 32'h4F800000, 1'b1},
      '{32'h80000000, 1'b0, 3'd0, 32'hCF000000, 32'hCF000000, 1'b0},
      '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, 32'h4B800000, 1'b1},
      '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, 32'h4B800000, 1'b1},
      '{32'hFEFFFFFF, 1'b0, 3'd2, 32'hCB800001, 32'hCB800000, 1'b1},
      '{32'h01000003, 1'b0, 3'd6, 32'h4B800002, 32'h4B800002, 1'b1}
   };
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   itof_rm_pipe_if #(.IN_W(32), .TAG_W(4)) io ();
   itof_rm_pipe #(.IN_W(32), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int acc_cyc = 0;
   int fire_cyc = 0;
   int n_in = 0;
   int n_out = 0;
   bit last_acc = 1'b0;
   bit prev_stall = 1'b0;
   logic [36:0] prev_out = '0;
   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // independent reference: locate the msb, shift right, split off guard and sticky
   function automatic logic [32:0] model(input logic [31:0] d, input logic u, input logic [2:0] rm_in);
      logic s, g, st, inc;
      logic [31:0] m32, f;
      logic [63:0] m, mn, rem;
      logic [2:0] rm;
      int p;
      s = !u && d[31];
      m32 = s ? (~d + 32'd1) : d;
      m = {32'd0, m32};
      if (m == 0) return 33'd0;
      p = 31;
      while (!m[p]) p--;
      if (p <= 23) begin
         mn = m << (23 - p);
         g = 1'b0;
         st = 1'b0;
      end else begin
         mn = m >> (p - 23);
         rem = m & ((64'd1 << (p - 23)) - 64'd1);
         g = rem[p - 24];
         st = (rem & ((64'd1 << (p - 24)) - 64'd1)) != 64'd0;
      end
      rm = (RM_EN && rm_in <= 3'd4) ? rm_in : 3'd0;
      case (rm)
         3'd1: inc = 1'b0;
         3'd2: inc = (g || st) && s;
         3'd3: inc = (g || st) && !s;
         3'd4: inc = g;
         default: inc = g && (st || mn[0]);
      endcase
      f = {s, 8'(127 + p), mn[22:0]};
      f = {s, f[30:0] + 31'(inc)};
      return {g || st, f};
   endfunction

   task automatic cyc(input logic iv, input logic [31:0] d, input logic u, input logic [2:0] rm,
                      input logic [3:0] t, input logic ordy, input exp_t e);
      exp_t x;
      cyc_n++;
      io.in_valid = iv;
      io.in_data = d;
      io.in_unsigned = u;
      io.in_rm = rm;
      io.in_tag = t;
      io.out_ready = ordy;
      #1;
      last_acc = 1'b0;
      if (rst_n) begin
         if (prev_stall) check("hold", {io.out_data, io.out_nx, io.out_tag}, prev_out);
         prev_stall = io.out_valid && !io.out_ready;
         prev_out = {io.out_data, io.out_nx, io.out_tag};
         if (io.out_valid && io.out_ready) begin
            n_out++;
            fire_cyc = cyc_n;
            if (sb.size() == 0) check("spurious", io.out_valid, 1'b0);
            else begin
               x = sb.pop_front();
               check("data", io.out_data, x.d);
               check("nx", io.out_nx, x.nx);
               check("tag", io.out_tag, x.t);
            end
         end
         if (iv && io.in_ready) begin
            last_acc = 1'b1;
            acc_cyc = cyc_n;
            n_in++;
            sb.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   function automatic exp_t mk(input logic [31:0] d, input logic u, input logic [2:0] rm, input logic [3:0] t);
      logic [32:0] r;
      r = model(d, u, rm);
      return '{d: r[31:0], nx: r[32], t: t};
   endfunction

   task automatic idle(input logic ordy);
      cyc(1'b0, 32'd0, 1'b0, 3'd0, 4'd0, ordy, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(1'b1, 32'h12345678, 1'b0, 3'd0, 4'hF, 1'b1, '0);
      rst_n = 1'b1;
      sb.delete();
      prev_stall = 1'b0;
      io.in_valid = 1'b0;
      #1;
      check("rst_out_valid", io.out_valid, 1'b0);
      check("rst_out_data", io.out_data, 32'd0);
      check("rst_out_nx", io.out_nx, 1'b0);
      check("rst_out_tag", io.out_tag, 4'd0);
      check("rst_in_ready", io.in_ready, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic latency(input logic [31:0] d);
      int f0;
      cyc(1'b1, d, 1'b0, 3'd0, 4'h9, 1'b1, mk(d, 1'b0, 3'd0, 4'h9));
      f0 = n_out;
      for (int i = 0; i < 8 && n_out == f0; i++) idle(1'b1);
      check("latency", fire_cyc - acc_cyc, 3);
   endtask

   initial begin
      io.in_valid = 1'b0;
      io.in_data = '0;
      io.in_unsigned = 1'b0;
      io.in_rm = '0;
      io.in_tag = '0;
      io.out_ready = 1'b1;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("no_accept_in_reset", n_out, 0);
      latency(32'h00000007);
      // directed vectors, back to back
      for (int i = 0; i < 14; i++) begin
         cyc(1'b1, VECS[i].d, VECS[i].u, VECS[i].rm, 4'(i), 1'b1,
             '{d: RM_EN ? VECS[i].e_rm : VECS[i].e_rne, nx: VECS[i].nx, t: 4'(i)});
         check("b2b_accept", last_acc, 1'b1);
      end
      drain();
      // backpressure: five tagged operands against a stalled consumer
      begin
         int t, o0;
         t = 1;
         for (int i = 0; i < 6; i++) begin
            cyc(t <= 5, 32'(t * 1000 + 3), 1'b0, 3'd0, 4'(t), 1'b0, mk(32'(t * 1000 + 3), 1'b0, 3'd0, 4'(t)));
            if (last_acc) t++;
         end
         check("bp_accepted", t - 1, 3);
         check("bp_in_ready", io.in_ready, 1'b0);
         check("bp_out_valid", io.out_valid, 1'b1);
         o0 = n_out;
         for (int i = 0; i < 5; i++) begin
            cyc(t <= 5, 32'(t * 1000 + 3), 1'b0, 3'd0, 4'(t), 1'b1, mk(32'(t * 1000 + 3), 1'b0, 3'd0, 4'(t)));
            if (last_acc) t++;
         end
         check("bp_rate", n_out - o0, 5);
         check("bp_all_in", t, 6);
      end
      drain();
      // random traffic
      begin
         int sent, guard;
         logic [31:0] d;
         logic u;
         logic [2:0] rm;
         sent = 0;
         guard = 0;
         while (sent < 3000 && guard < 20000) begin
            guard++;
            case ($urandom_range(0, 5))
               0: d = $urandom;
               1: d = 32'd0;
               2: d = $urandom_range(0, 255);
               3: d = 32'h80000000 | ($urandom & 32'd1);
               4: d = (32'd1 << $urandom_range(0, 31)) + $urandom_range(0, 2);
               default: d = ~$urandom_range(0, 255);
            endcase
            u = $urandom_range(0, 1) == 1;
            rm = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 9) < 7, d, u, rm, 4'(sent), $urandom_range(0, 9) < 7, mk(d, u, rm, 4'(sent)));
            if (last_acc) sent++;
         end
         check("rand_sent", sent, 3000);
      end
      drain();
      check("in_out_count", n_out, n_in);
      // reset with three operands in flight
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'(i + 5), 1'b0, 3'd0, 4'(i), 1'b1, mk(32'(i + 5), 1'b0, 3'd0, 4'(i)));
      begin
         int o0;
         o0 = n_out;
         do_reset();
         for (int i = 0; i < 5; i++) idle(1'b1);
         check("flush_no_output", n_out - o0, 0);
      end
      latency(32'hFFFFF000);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
